spm_memory_responder: RTL and testbench
=======================================

// Module: spm_memory_responder
// PURPOSE
//  Memory-side responder for the RISC SPM control unit: owns the address register (Add_R), the
//  256x8 program/data RAM and the mem_word return path, and commits write requests.
//  Also contains a boot loader: after reset it holds the CPU in reset, streams program bytes into
//  RAM over a valid/ready handshake, then releases the CPU. It sits between the control unit and
//  the processing unit's Bus_1/Bus_2 and an external boot source.
// PARAMETERS
//  AW             8   address width; DEPTH = 2**AW words
//  DW             8   data word width (instruction and operand width)
//  BOOT_ON_RESET  1   1: reset enters LOAD; 0: reset enters RUN directly from preset RAM contents
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  load_add_r   in   1   from control unit Load_Add_R: capture addr_in into Add_R
//  addr_in      in   AW  Bus_2 value (low AW bits)
//  write        in   1   from control unit write: store data_in at Add_R
//  data_in      in   DW  Bus_1 value (source register)
//  mem_word     out  DW  RAM[Add_R], feeds Bus_2 mux input 2
//  add_r        out  AW  current address register
//  boot_req     in   1   pulse: re-enter LOAD from RUN
//  boot_valid   in   1   boot byte valid
//  boot_data    in   DW  boot byte
//  boot_last    in   1   qualifies final boot byte
//  boot_ready   out  1   loader accepts boot byte this cycle
//  cpu_rst_n    out  1   active-low reset for control unit/datapath, registered
//  boot_done    out  1   high while in RUN
//  wr_err       out  1   sticky: write asserted outside RUN
// BEHAVIOUR
//  Reset: state=LOAD if BOOT_ON_RESET else RUN; add_r=0, boot_ptr=0, cpu_rst_n=0, boot_ready=0,
//   boot_done=0, wr_err=0. RAM contents are NOT reset. mem_word = RAM[0] combinationally.
//  States: LOAD, RELEASE, RUN (3; encoding from package).
//   LOAD: boot_ready=1; on boot_valid&boot_ready: RAM[boot_ptr]<=boot_data, boot_ptr++.
//    Exit to RELEASE when accepted byte has boot_last=1 or boot_ptr==DEPTH-1 (wrap never occurs).
//   RELEASE: one cycle; boot_ready=0; cpu_rst_n<=1 at end; add_r<=0; -> RUN.
//   RUN: boot_done=1, cpu_rst_n=1. boot_req=1 -> LOAD, boot_ptr<=0, cpu_rst_n<=0 same edge.
//  Add_R: in RUN, load_add_r=1 captures addr_in at posedge. Ignored outside RUN.
//  Read: mem_word = RAM[add_r], zero latency (asynchronous read); valid the cycle after load_add_r,
//   matching fet1->fet2, rd1->rd2, br1->br2 timing.
//  Write: in RUN, write=1 stores data_in at RAM[add_r] on posedge; mem_word shows new value next cycle.
//  Simultaneous load_add_r & write: write uses pre-edge add_r; add_r updates same edge.
//  write outside RUN: RAM unchanged, wr_err<=1 (cleared only by rst).
//  boot_valid outside LOAD: ignored, no RAM change.
//  boot_req while in LOAD/RELEASE: ignored.
//  Reset mid-LOAD: loader restarts at address 0; bytes already written remain.
//  All outputs except mem_word are registered.
// STRUCTURE
//  spm_pkg: state enum (LOAD/RELEASE/RUN), AW/DW defaults, opcode constants NOP..BRZ shared with
//   control unit and bench assembler.
//  Sub-module spm_ram: DEPTH x DW array, single sync write port, async read port; instantiated
//   once, write port muxed between loader (LOAD) and CPU (RUN).
// TESTING
//  1 Boot 4 bytes 0x51,0x00,0x10,0x62 with last on 4th -> RAM[0..3] match, boot_ready drops,
//    cpu_rst_n=1 exactly 2 cycles after last handshake, boot_done=1.
//  2 boot_valid toggled (gaps) -> only handshaked bytes stored, boot_ptr advances per accept only.
//  3 RUN: load_add_r addr_in=0x20 then write data_in=0xA5 -> RAM[0x20]=0xA5; mem_word=0xA5 next cycle.
//  4 load_add_r(0x30)&write same cycle with add_r=0x20 -> data lands at 0x20, add_r=0x30 after edge.
//  5 256 bytes without boot_last -> exits after address 0xFF, no overwrite of RAM[0].
//  6 write during LOAD -> RAM unchanged, wr_err=1; rst low mid-load -> cpu_rst_n=0, restart at 0.

Source files
------------

// File: rtl/spm_pkg.sv
// Shared definitions for the RISC SPM memory side: loader state encoding, default widths
// and the instruction opcodes used by the control unit and the bench assembler.
package spm_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Opcodes occupy the upper nibble of an instruction byte.
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  function automatic logic [7:0] spm_instr(input logic [3:0] op, input logic [1:0] src,
                                           input logic [1:0] dest);
    return {op, src, dest};
  endfunction

endpackage

// File: rtl/spm_ram.sv
// Program/data RAM for the SPM: one synchronous write port, one asynchronous read port.
module spm_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset; contents survive reset so a partial boot image is retained.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spm_memory_responder.sv
// Memory-side responder for the RISC SPM: address register, RAM, write commit and a boot
// loader that holds the CPU in reset while a program image is streamed into RAM.
module spm_memory_responder
  import spm_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_add_r,
  input  logic [AW-1:0] addr_in,
  input  logic          write,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] mem_word,
  output logic [AW-1:0] add_r,
  input  logic          boot_req,
  input  logic          boot_valid,
  input  logic [DW-1:0] boot_data,
  input  logic          boot_last,
  output logic          boot_ready,
  output logic          cpu_rst_n,
  output logic          boot_done,
  output logic          wr_err
);

  state_e        state_q;
  logic [AW-1:0] add_r_q;
  logic [AW-1:0] boot_ptr_q;
  logic          boot_ready_q;
  logic          cpu_rst_n_q;
  logic          boot_done_q;
  logic          wr_err_q;

  logic          boot_accept;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;

  // The single write port belongs to the loader in LOAD and to the CPU in RUN.
  assign boot_accept = (state_q == ST_LOAD) && boot_valid && boot_ready_q;
  assign ram_we      = boot_accept || ((state_q == ST_RUN) && write);
  assign ram_waddr   = (state_q == ST_RUN) ? add_r_q : boot_ptr_q;
  assign ram_wdata   = (state_q == ST_RUN) ? data_in : boot_data;

  spm_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(add_r_q),
    .rdata(mem_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT_ON_RESET ? ST_LOAD : ST_RUN;
      add_r_q      <= '0;
      boot_ptr_q   <= '0;
      boot_ready_q <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      boot_done_q  <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      if (write && (state_q != ST_RUN)) begin
        wr_err_q <= 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          cpu_rst_n_q  <= 1'b0;
          boot_done_q  <= 1'b0;
          boot_ready_q <= 1'b1;
          if (boot_accept) begin
            boot_ptr_q <= boot_ptr_q + 1'b1;
            // The top address always ends the image, so the pointer never wraps onto RAM[0].
            if (boot_last || (boot_ptr_q == '1)) begin
              state_q      <= ST_RELEASE;
              boot_ready_q <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          boot_ready_q <= 1'b0;
          cpu_rst_n_q  <= 1'b1;
          boot_done_q  <= 1'b1;
          add_r_q      <= '0;
          state_q      <= ST_RUN;
        end
        ST_RUN: begin
          boot_ready_q <= 1'b0;
          cpu_rst_n_q  <= 1'b1;
          boot_done_q  <= 1'b1;
          if (load_add_r) begin
            add_r_q <= addr_in;
          end
          if (boot_req) begin
            state_q      <= ST_LOAD;
            boot_ptr_q   <= '0;
            cpu_rst_n_q  <= 1'b0;
            boot_done_q  <= 1'b0;
            boot_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  assign add_r      = add_r_q;
  assign boot_ready = boot_ready_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign boot_done  = boot_done_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_spm_memory_responder.sv
// Self-checking bench for spm_memory_responder: boot loading, CPU read/write, error and reset paths.
module tb_spm_memory_responder;
  import spm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_add_r, write, boot_req, boot_valid, boot_last;
  logic [7:0] addr_in, data_in, boot_data;
  logic [7:0] mem_word, add_r;
  logic       boot_ready, cpu_rst_n, boot_done, wr_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model [256];
  logic [7:0] boot_buf [256];
  logic [7:0] exp_q [$];
  int         boot_ptr_m;
  logic [7:0] add_r_m;

  always #5 clk = ~clk;

  spm_memory_responder dut (
    .clk       (clk),
    .rst       (rst),
    .load_add_r(load_add_r),
    .addr_in   (addr_in),
    .write     (write),
    .data_in   (data_in),
    .mem_word  (mem_word),
    .add_r     (add_r),
    .boot_req  (boot_req),
    .boot_valid(boot_valid),
    .boot_data (boot_data),
    .boot_last (boot_last),
    .boot_ready(boot_ready),
    .cpu_rst_n (cpu_rst_n),
    .boot_done (boot_done),
    .wr_err    (wr_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams boot_buf[0..n-1]; optional idle gaps with junk data between bytes.
  task automatic boot_stream(input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int waited;
      if (gaps && (i % 2 == 1)) begin
        boot_valid = 1'b0;
        boot_data  = 8'($urandom);
        boot_last  = 1'b1;
        tick();
      end
      boot_valid = 1'b1;
      boot_data  = boot_buf[i];
      boot_last  = use_last && (i == n - 1);
      acc        = 1'b0;
      waited     = 0;
      while (!acc && waited < 20) begin
        acc = boot_ready;
        tick();
        waited++;
      end
      if (!acc) begin
        check("boot_handshake_timeout", 32'(acc), 32'd1);
        break;
      end
      model[boot_ptr_m[7:0]] = boot_buf[i];
      boot_ptr_m++;
    end
    boot_valid = 1'b0;
    boot_last  = 1'b0;
  endtask

  task automatic check_release(input string tag);
    check({tag, "_rel_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({tag, "_rel_boot_ready"}, 32'(boot_ready), 32'd0);
    tick();
    check({tag, "_run_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    check({tag, "_run_boot_done"}, 32'(boot_done), 32'd1);
    check({tag, "_run_add_r"}, 32'(add_r), 32'd0);
    add_r_m = 8'h00;
  endtask

  task automatic load_addr(input logic [7:0] a);
    load_add_r = 1'b1;
    addr_in    = a;
    tick();
    load_add_r = 1'b0;
    add_r_m    = a;
  endtask

  task automatic read_at(input string tag, input logic [7:0] a);
    exp_q.push_back(model[a]);
    load_addr(a);
    check(tag, 32'(mem_word), 32'(exp_q.pop_front()));
  endtask

  task automatic cpu_write(input logic [7:0] d);
    write   = 1'b1;
    data_in = d;
    tick();
    write   = 1'b0;
    model[add_r_m] = d;
  endtask

  task automatic enter_load(input bit with_addr, input logic [7:0] a);
    boot_req   = 1'b1;
    load_add_r = with_addr;
    addr_in    = a;
    tick();
    boot_req   = 1'b0;
    load_add_r = 1'b0;
    if (with_addr) add_r_m = a;
    boot_ptr_m = 0;
  endtask

  initial begin
    rst = 1'b0;
    {load_add_r, write, boot_req, boot_valid, boot_last} = '0;
    addr_in = '0; data_in = '0; boot_data = '0;
    boot_ptr_m = 0;
    add_r_m = 8'h00;
    repeat (2) tick();

    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_boot_ready", 32'(boot_ready), 32'd0);
    check("rst_boot_done", 32'(boot_done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_add_r", 32'(add_r), 32'd0);
    rst = 1'b1;
    tick();
    check("load_boot_ready", 32'(boot_ready), 32'd1);

    // Program boot with idle gaps between handshakes.
    boot_buf[0] = spm_instr(OP_RD, 2'b00, 2'b01);
    boot_buf[1] = 8'h00;
    boot_buf[2] = spm_instr(OP_ADD, 2'b00, 2'b00);
    boot_buf[3] = spm_instr(OP_WR, 2'b00, 2'b10);
    boot_stream(4, 1'b1, 1'b1);
    check_release("boot4");
    for (int a = 0; a < 4; a++) read_at("boot4_ram", 8'(a));

    // CPU write, then simultaneous load_add_r and write.
    load_addr(8'h30);
    cpu_write(8'h11);
    load_addr(8'h20);
    cpu_write(8'hA5);
    check("wr_next_cycle", 32'(mem_word), 32'hA5);
    load_add_r = 1'b1; addr_in = 8'h30; write = 1'b1; data_in = 8'h5A;
    tick();
    load_add_r = 1'b0; write = 1'b0;
    model[8'h20] = 8'h5A;
    add_r_m = 8'h30;
    check("simul_add_r", 32'(add_r), 32'h30);
    check("simul_old_addr_kept", 32'(mem_word), 32'h11);
    read_at("simul_ram20", 8'h20);

    // boot_valid during RUN is ignored.
    boot_valid = 1'b1; boot_data = 8'hFF;
    tick();
    check("run_boot_ready", 32'(boot_ready), 32'd0);
    boot_valid = 1'b0;
    read_at("run_bootvalid_ram0", 8'h00);
    check("run_wr_err", 32'(wr_err), 32'd0);

    // Write while loading: RAM untouched, sticky error.
    load_addr(8'h40);
    cpu_write(8'h3C);
    enter_load(1'b1, 8'h40);
    check("reboot_add_r", 32'(add_r), 32'h40);
    check("reboot_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("reboot_boot_done", 32'(boot_done), 32'd0);
    write = 1'b1; data_in = 8'hEE;
    tick();
    write = 1'b0;
    check("load_wr_err", 32'(wr_err), 32'd1);
    boot_buf[0] = 8'hA1;
    boot_buf[1] = 8'hA2;
    boot_stream(2, 1'b1, 1'b0);
    check_release("boot2");
    read_at("load_write_ignored", 8'h40);
    read_at("boot2_ram0", 8'h00);
    read_at("boot2_ram1", 8'h01);
    read_at("boot2_ram2_kept", 8'h02);

    // Full image without boot_last; boot_req mid-load must be ignored.
    enter_load(1'b0, 8'h00);
    for (int i = 0; i < 256; i++) boot_buf[i] = 8'(i) ^ 8'hC3;
    boot_stream(100, 1'b0, 1'b0);
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
    for (int i = 0; i < 156; i++) boot_buf[i] = boot_buf[i + 100];
    boot_stream(156, 1'b0, 1'b0);
    check_release("boot256");
    boot_valid = 1'b1; boot_data = 8'h00;
    repeat (3) tick();
    boot_valid = 1'b0;
    read_at("full_ram00", 8'h00);
    read_at("full_ram7f", 8'h7F);
    read_at("full_ramff", 8'hFF);
    check("wr_err_sticky", 32'(wr_err), 32'd1);

    // Reset during a load: loader restarts at 0, earlier bytes remain.
    enter_load(1'b0, 8'h00);
    boot_buf[0] = 8'hC0; boot_buf[1] = 8'hC1; boot_buf[2] = 8'hC2;
    boot_stream(3, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("midrst_boot_ready", 32'(boot_ready), 32'd0);
    check("midrst_wr_err", 32'(wr_err), 32'd0);
    check("midrst_mem_word", 32'(mem_word), 32'hC0);
    tick();
    rst = 1'b1;
    boot_ptr_m = 0;
    boot_buf[0] = 8'hD0; boot_buf[1] = 8'hD1;
    boot_stream(2, 1'b1, 1'b0);
    check_release("boot_after_rst");
    read_at("midrst_ram0", 8'h00);
    read_at("midrst_ram1", 8'h01);
    read_at("midrst_ram2_kept", 8'h02);
    read_at("midrst_ram3_kept", 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
